// File: rtl/pbpix_tx.sv
`default_nettype none
// ============================================================================
//  Module   : pbpix_tx
//  Purpose  : Packed-word to pbpix serializer with 2-entry word buffer
//  Revision : 1.0 - initial release
// ============================================================================
module pbpix_tx #(
  parameter int BW   = 8,
  parameter int NPIX = 4,
  localparam int IW  = $clog2(NPIX)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               word_rdy,
  output logic               word_ack,
  input  logic [NPIX*BW-1:0] word,
  input  logic               word_last,
  output logic               pix_rdy,
  input  logic               pix_ack,
  output logic               pix_zero,
  output logic [BW-1:0]      pix,
  output logic [IW-1:0]      pix_idx,
  output logic               pix_last,
  output logic               busy
);

  localparam logic [IW-1:0] c_idx_max = IW'(NPIX - 1);

  logic [NPIX*BW-1:0] r_word0, r_word1, w_word0_nxt, w_word1_nxt;
  logic               r_last0, r_last1, w_last0_nxt, w_last1_nxt;
  logic [1:0]         r_cnt, w_cnt_nxt;
  logic [IW-1:0]      r_idx, w_idx_nxt;
  logic               w_push, w_xfer, w_pop;
  logic [BW-1:0]      w_pixels [NPIX];

  // Handshakes depend on registered occupancy only
  assign word_ack = (r_cnt != 2'd2);
  assign pix_rdy  = (r_cnt != 2'd0);
  assign busy     = pix_rdy;

  assign w_push = word_rdy && word_ack;
  assign w_xfer = pix_rdy && pix_ack;
  assign w_pop  = w_xfer && (r_idx == c_idx_max);

  for (genvar k = 0; k < NPIX; k++) begin : g_unpack
    assign w_pixels[k] = r_word0[k*BW +: BW];
  end

  assign pix      = pix_rdy ? w_pixels[r_idx] : '0;
  assign pix_zero = pix_rdy && (w_pixels[r_idx] == '0);
  assign pix_idx  = pix_rdy ? r_idx : '0;
  assign pix_last = pix_rdy && r_last0 && (r_idx == c_idx_max);

  always_comb begin
    w_word0_nxt = r_word0;
    w_last0_nxt = r_last0;
    w_word1_nxt = r_word1;
    w_last1_nxt = r_last1;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;

    if (w_xfer) begin
      w_idx_nxt = w_pop ? '0 : r_idx + 1'b1;
    end

    if (w_pop) begin
      w_word0_nxt = r_word1;
      w_last0_nxt = r_last1;
      w_word1_nxt = '0;
      w_last1_nxt = 1'b0;
    end

    // A push lands in slot0 when the buffer is (or is becoming) empty
    if (w_push) begin
      if ((r_cnt == 2'd0) || (w_pop && r_cnt == 2'd1)) begin
        w_word0_nxt = word;
        w_last0_nxt = word_last;
      end else begin
        w_word1_nxt = word;
        w_last1_nxt = word_last;
      end
    end

    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_word0 <= '0;
      r_last0 <= 1'b0;
      r_word1 <= '0;
      r_last1 <= 1'b0;
      r_cnt   <= 2'd0;
      r_idx   <= '0;
    end else begin
      r_word0 <= w_word0_nxt;
      r_last0 <= w_last0_nxt;
      r_word1 <= w_word1_nxt;
      r_last1 <= w_last1_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pbpix_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pbpix_tx
//  Purpose  : Self-checking bench for pbpix_tx against a queue-based model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pbpix_tx;

  localparam int BW   = 8;
  localparam int NPIX = 4;
  localparam int IW   = 2;
  localparam int W    = NPIX * BW;

  typedef struct packed {logic [W-1:0] w; logic l;} wd_t;
  typedef struct packed {logic [BW-1:0] p; logic z; logic [IW-1:0] i; logic l;} px_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          word_rdy = 1'b0;
  logic [W-1:0]  word = '0;
  logic          word_last = 1'b0;
  logic          pix_ack = 1'b0;
  logic          word_ack, pix_rdy, pix_zero, pix_last, busy;
  logic [BW-1:0] pix;
  logic [IW-1:0] pix_idx;

  int  n_chk = 0;
  int  n_fail = 0;
  int  n_dut_xfer = 0;
  int  mpos = 0;
  int  base;
  wd_t sq[$];
  wd_t mq[$];
  px_t lq[$];

  always #5 clk = ~clk;

  pbpix_tx #(.BW(BW), .NPIX(NPIX)) u_dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .word_rdy (word_rdy),
    .word_ack (word_ack),
    .word     (word),
    .word_last(word_last),
    .pix_rdy  (pix_rdy),
    .pix_ack  (pix_ack),
    .pix_zero (pix_zero),
    .pix      (pix),
    .pix_idx  (pix_idx),
    .pix_last (pix_last),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: present the head of the source queue, compare against the
  // model, then advance the model with the handshakes that took place.
  task automatic cycle(input logic pa);
    logic          e_ack, e_rdy, e_last, push, xfer;
    logic [W-1:0]  tw;
    logic [BW-1:0] e_pix;
    px_t           ent;
    word_rdy  = (sq.size() != 0);
    word      = '0;
    word_last = 1'b0;
    if (word_rdy) begin
      word      = sq[0].w;
      word_last = sq[0].l;
    end
    pix_ack = pa;
    e_ack  = (mq.size() != 2);
    e_rdy  = (mq.size() != 0);
    tw     = '0;
    e_last = 1'b0;
    if (e_rdy) begin
      tw     = mq[0].w;
      e_last = mq[0].l && (mpos == NPIX - 1);
    end
    e_pix = tw[mpos*BW +: BW];
    chk("word_ack", word_ack, e_ack);
    chk("pix_rdy", pix_rdy, e_rdy);
    chk("busy", busy, e_rdy);
    chk("pix", pix, e_pix);
    chk("pix_zero", pix_zero, e_rdy && (e_pix == 0));
    chk("pix_idx", pix_idx, e_rdy ? mpos : 0);
    chk("pix_last", pix_last, e_last);
    push = word_rdy && e_ack;
    xfer = e_rdy && pa;
    if (pix_rdy && pa) begin
      n_dut_xfer++;
      ent.p = pix; ent.z = pix_zero; ent.i = pix_idx; ent.l = pix_last;
      lq.push_back(ent);
    end
    @(posedge clk);
    #1;
    if (!rstn) begin
      mq.delete();
      mpos = 0;
    end else begin
      if (xfer) begin
        mpos++;
        if (mpos == NPIX) begin
          mpos = 0;
          void'(mq.pop_front());
        end
      end
      if (push) mq.push_back(sq.pop_front());
    end
  endtask

  task automatic send(input logic [W-1:0] w, input logic l);
    wd_t e;
    e.w = w; e.l = l;
    sq.push_back(e);
  endtask

  initial begin
    logic [W-1:0] rw;
    logic [7:0]   exp_p [4];
    logic         exp_z [4];

    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("rst_word_ack", word_ack, 1);
    chk("rst_pix_rdy", pix_rdy, 0);
    chk("rst_pix", pix, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pix_last", pix_last, 0);

    // Single word, continuous downstream accept
    lq.delete();
    send(32'h04_00_02_01, 1'b1);
    repeat (7) cycle(1'b1);
    exp_p = '{8'h01, 8'h02, 8'h00, 8'h04};
    exp_z = '{1'b0, 1'b0, 1'b1, 1'b0};
    chk("t1_count", lq.size(), 4);
    for (int k = 0; k < 4 && k < lq.size(); k++) begin
      chk("t1_pix", lq[k].p, exp_p[k]);
      chk("t1_zero", lq[k].z, exp_z[k]);
      chk("t1_idx", lq[k].i, k);
      chk("t1_last", lq[k].l, (k == 3));
    end

    // Buffer fill with downstream stalled
    send(32'h44_33_22_11, 1'b0);
    send(32'h88_77_66_55, 1'b0);
    send(32'hCC_BB_AA_99, 1'b1);
    repeat (5) cycle(1'b0);
    chk("t2_full_ack", word_ack, 0);
    chk("t2_hold_pix", pix, 8'h11);
    repeat (4) cycle(1'b1);
    chk("t2_reopen_ack", word_ack, 1);
    repeat (10) cycle(1'b1);

    // Back-to-back words, 12 pixels in 12 consecutive cycles
    base = n_dut_xfer;
    send(32'h0C_0B_0A_09, 1'b0);
    send(32'h10_0F_0E_0D, 1'b0);
    send(32'h14_13_12_11, 1'b1);
    repeat (13) cycle(1'b1);
    chk("t3_xfers", n_dut_xfer - base, 12);
    repeat (2) cycle(1'b1);

    // Toggling downstream accept
    lq.delete();
    send(32'hFF_00_00_80, 1'b1);
    for (int c = 0; c < 12; c++) cycle(c[0] == 1'b0);
    exp_p = '{8'h80, 8'h00, 8'h00, 8'hFF};
    exp_z = '{1'b0, 1'b1, 1'b1, 1'b0};
    chk("t4_count", lq.size(), 4);
    for (int k = 0; k < 4 && k < lq.size(); k++) begin
      chk("t4_pix", lq[k].p, exp_p[k]);
      chk("t4_zero", lq[k].z, exp_z[k]);
    end

    // Reset with cnt=2, idx=2
    send(32'h01_02_03_04, 1'b0);
    send(32'h05_06_07_08, 1'b0);
    send(32'h09_0A_0B_0C, 1'b1);
    repeat (2) cycle(1'b0);
    repeat (2) cycle(1'b1);
    chk("t5_pre_idx", pix_idx, 2);
    chk("t5_pre_ack", word_ack, 0);
    sq.delete();
    rstn = 1'b0;
    cycle(1'b0);
    rstn = 1'b1;
    chk("t5_ack", word_ack, 1);
    chk("t5_rdy", pix_rdy, 0);
    chk("t5_pix", pix, 0);
    chk("t5_busy", busy, 0);
    lq.delete();
    send(32'h0A_0B_0C_0D, 1'b1);
    repeat (6) cycle(1'b1);
    chk("t5_count", lq.size(), 4);
    if (lq.size() > 0) begin
      chk("t5_first_idx", lq[0].i, 0);
      chk("t5_first_pix", lq[0].p, 8'h0D);
    end

    // All-zero word: every pixel still transferred
    lq.delete();
    send(32'h0, 1'b1);
    repeat (6) cycle(1'b1);
    chk("t6_count", lq.size(), 4);
    for (int k = 0; k < 4 && k < lq.size(); k++) begin
      chk("t6_zero", lq[k].z, 1);
      chk("t6_idx", lq[k].i, k);
    end

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (sq.size() < 2 && ($urandom % 3) != 0) begin
        for (int k = 0; k < NPIX; k++)
          rw[k*BW +: BW] = (($urandom % 3) == 0) ? 8'h00 : 8'($urandom);
        send(rw, 1'($urandom % 2));
      end
      cycle(($urandom % 4) != 0);
    end
    repeat (20) cycle(1'b1);
    chk("rand_drained", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
